// File: rtl/digit_scanner_pkg.sv
// Shared definitions for the digit scanner: sequencer state encodings,
// the number of display digits, and small elaboration-time helpers.
package digit_scanner_pkg;

    // Sequencer states. The encodings are fixed because other blocks
    // that observe the scanner rely on them.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

    localparam int N_DIGITS = 4;

    // Width of the shared phase counter. It must hold max(DIV, BLANK) - 1.
    // The result is kept at one bit or more so that DIV = BLANK = 1 still
    // elaborates.
    function automatic int cnt_width(input int div, input int blank);
        int max_len;
        int w;
        max_len = (div > blank) ? div : blank;
        w       = $clog2(max_len);
        return (w < 1) ? 1 : w;
    endfunction

    // One-hot digit enable for the given digit index.
    function automatic logic [N_DIGITS-1:0] digit_onehot(input logic [1:0] idx);
        logic [N_DIGITS-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/digit_scanner_mod_counter.sv
// Up-counter with a run-time terminal value. When the count reaches the
// terminal value while enabled, it returns to zero on the same edge, and
// `wrap` flags the terminal count combinationally. The scanner uses one
// instance of this counter for both the blanking phase and the show phase.
module digit_scanner_mod_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] term,
    output logic             wrap
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Terminal-count detect and next-count selection. `clear` takes
    // priority over counting.
    always_comb begin
        wrap    = (count_q == term);
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = wrap ? '0 : count_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/digit_scanner.sv
// Digit scanner for a 4-digit multiplexed display.
// sel[0] drives the first-level muxes and sel[1] drives the second-level
// mux. Before each digit lights, there is a blanking interval so that the
// mux output can settle first, which avoids ghosting.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | scanning disabled, display dark, sel parked
//   ST_BLANK | display dark for BLANK cycles, sel already on target digit
//   ST_SHOW  | digit sel lit for DIV cycles (frozen while hold is high)
module digit_scanner
    import digit_scanner_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int BLANK = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       hold,
    output logic [1:0] sel,
    output logic [3:0] digit_en,
    output logic       frame_done
);

    localparam int              CNT_W    = cnt_width(DIV, BLANK);
    localparam logic [CNT_W-1:0] DIV_TC   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_TC = CNT_W'(BLANK - 1);
    localparam logic [1:0]       LAST_DIG = 2'(N_DIGITS - 1);

    scan_state_t state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [3:0]  digit_en_q, digit_en_d;
    logic        frame_done_q, frame_done_d;

    logic             cnt_clear;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_term;
    logic             cnt_wrap;

    // A single counter serves both phases. Its terminal value follows the
    // current state.
    digit_scanner_mod_counter #(
        .WIDTH (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .en    (cnt_en),
        .term  (cnt_term),
        .wrap  (cnt_wrap)
    );

    // Next-state, counter control and next-output logic. A low enable
    // overrides everything except reset. hold matters only in SHOW.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        digit_en_d   = 4'b0000;
        frame_done_d = 1'b0;
        cnt_clear    = 1'b0;
        cnt_en       = 1'b0;
        cnt_term     = (state_q == ST_SHOW) ? DIV_TC : BLANK_TC;

        if (!enable) begin
            state_d   = ST_IDLE;
            cnt_clear = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Resume on the parked digit with a full blanking
                    // interval.
                    state_d   = ST_BLANK;
                    cnt_clear = 1'b1;
                end
                ST_BLANK: begin
                    cnt_en = 1'b1;
                    if (cnt_wrap) begin
                        state_d    = ST_SHOW;
                        digit_en_d = digit_onehot(sel_q);
                    end
                end
                ST_SHOW: begin
                    digit_en_d = digit_onehot(sel_q);
                    if (!hold) begin
                        cnt_en = 1'b1;
                        if (cnt_wrap) begin
                            // sel advances on the same edge that blanks
                            // the display, so no lit digit sees it move.
                            state_d      = ST_BLANK;
                            sel_d        = sel_q + 2'd1;
                            digit_en_d   = 4'b0000;
                            frame_done_d = (sel_q == LAST_DIG);
                        end
                    end
                end
                default: begin
                    state_d   = ST_BLANK;
                    cnt_clear = 1'b1;
                end
            endcase
        end
    end

    // Registers for state and outputs. Reset restarts the scan at digit 0
    // with blanking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_BLANK;
            sel_q        <= 2'd0;
            digit_en_q   <= 4'b0000;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            digit_en_q   <= digit_en_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign sel        = sel_q;
    assign digit_en   = digit_en_q;
    assign frame_done = frame_done_q;

endmodule
